// File: rtl/hex_scan_scheduler_if.sv
// Frame handoff from the display scheduler to the 74HC595 shifter controller.
// Data is {segments[7:0], anodes[3:0]}, held stable while valid and not ready.
interface hex_scan_scheduler_if;
  logic [11:0] o_data;
  logic        o_vld;
  logic        i_rdy;

  modport master (output o_data, output o_vld, input i_rdy);
  modport slave  (input o_data, input o_vld, output i_rdy);
endinterface

// File: rtl/hex_scan_scheduler.sv
// Scans four hex digits into 12-bit shifter frames, one digit per handshake, DWELL_CYCLES apart.
// Latency: frame valid one cycle after PREP; stalls in SEND while i_rdy=0, display value swaps only at LOAD.
module hex_scan_scheduler #(
  parameter int DWELL_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          i_value,
  input  logic [3:0]           i_dp,
  input  logic [3:0]           i_blank,
  input  logic                 i_load,
  output logic                 o_frame_start,
  hex_scan_scheduler_if.master shf
);

  localparam int CW = $clog2(DWELL_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {LOAD, PREP, SEND, DWELL} state_t;

  state_t        state_q, state_d;
  logic [15:0]   value_q, value_d;
  logic [3:0]    dp_q, dp_d;
  logic [3:0]    blank_q, blank_d;
  logic [15:0]   pend_value_q, pend_value_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic [3:0]    pend_blank_q, pend_blank_d;
  logic          pend_flag_q, pend_flag_d;
  logic [1:0]    digit_q, digit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   data_q, data_d;
  logic          vld_q, vld_d;
  logic          frame_start_q, frame_start_d;

  logic [3:0]    cur_nib;
  logic [7:0]    cur_seg;
  logic [11:0]   cur_frame;
  logic          accept;
  logic          dwell_done;

  assign accept     = vld_q & shf.i_rdy;
  assign dwell_done = (cnt_q == CNT_LAST);

  // Active-low common-anode font; blanking overrides the decimal point.
  always_comb begin
    cur_nib = 4'(value_q >> {digit_q, 2'b00});
    case (cur_nib)
      4'h0: cur_seg = 8'hC0;
      4'h1: cur_seg = 8'hF9;
      4'h2: cur_seg = 8'hA4;
      4'h3: cur_seg = 8'hB0;
      4'h4: cur_seg = 8'h99;
      4'h5: cur_seg = 8'h92;
      4'h6: cur_seg = 8'h82;
      4'h7: cur_seg = 8'hF8;
      4'h8: cur_seg = 8'h80;
      4'h9: cur_seg = 8'h90;
      4'hA: cur_seg = 8'h88;
      4'hB: cur_seg = 8'h83;
      4'hC: cur_seg = 8'hC6;
      4'hD: cur_seg = 8'hA1;
      4'hE: cur_seg = 8'h86;
      default: cur_seg = 8'h8E;
    endcase
    if (dp_q[digit_q]) begin
      cur_seg[7] = 1'b0;
    end
    if (blank_q[digit_q]) begin
      cur_seg = 8'hFF;
    end
    cur_frame = {cur_seg, ~(4'b0001 << digit_q)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LOAD;
      value_q       <= '0;
      dp_q          <= '0;
      blank_q       <= '0;
      pend_value_q  <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '0;
      pend_flag_q   <= 1'b0;
      digit_q       <= '0;
      cnt_q         <= '0;
      data_q        <= 12'hFFF;
      vld_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      value_q       <= value_d;
      dp_q          <= dp_d;
      blank_q       <= blank_d;
      pend_value_q  <= pend_value_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pend_flag_q   <= pend_flag_d;
      digit_q       <= digit_d;
      cnt_q         <= cnt_d;
      data_q        <= data_d;
      vld_q         <= vld_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:  state_d = PREP;
      PREP:  state_d = SEND;
      SEND:  if (accept) state_d = DWELL;
      DWELL: if (dwell_done) state_d = (digit_q == 2'd3) ? LOAD : PREP;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    value_d       = value_q;
    dp_d          = dp_q;
    blank_d       = blank_q;
    pend_value_d  = pend_value_q;
    pend_dp_d     = pend_dp_q;
    pend_blank_d  = pend_blank_q;
    pend_flag_d   = pend_flag_q;
    digit_d       = digit_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    vld_d         = vld_q;
    frame_start_d = 1'b0;

    if (i_load) begin
      pend_value_d = i_value;
      pend_dp_d    = i_dp;
      pend_blank_d = i_blank;
      pend_flag_d  = 1'b1;
    end

    case (state_q)
      LOAD: begin
        // A load arriving in this very cycle bypasses staging so it lands in this frame.
        if (i_load) begin
          value_d = i_value;
          dp_d    = i_dp;
          blank_d = i_blank;
        end else if (pend_flag_q) begin
          value_d = pend_value_q;
          dp_d    = pend_dp_q;
          blank_d = pend_blank_q;
        end
        pend_flag_d   = 1'b0;
        digit_d       = 2'd0;
        frame_start_d = 1'b1;
      end
      PREP: begin
        data_d = cur_frame;
        vld_d  = 1'b1;
      end
      SEND: begin
        if (accept) begin
          vld_d = 1'b0;
          cnt_d = '0;
        end
      end
      DWELL: begin
        if (dwell_done) begin
          cnt_d = '0;
          if (digit_q != 2'd3) begin
            digit_d = digit_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign shf.o_data    = data_q;
  assign shf.o_vld     = vld_q;
  assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_hex_scan_scheduler.sv
// Random loads, backpressure and resets against a frame-level model of the display scan.
module tb_hex_scan_scheduler;
  localparam int DW     = 4;
  localparam int PERIOD = 4 * (DW + 2) + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_value;
  logic [3:0]  i_dp, i_blank;
  logic        i_load;
  logic        o_frame_start;

  hex_scan_scheduler_if shf ();

  hex_scan_scheduler #(.DWELL_CYCLES(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_value      (i_value),
    .i_dp         (i_dp),
    .i_blank      (i_blank),
    .i_load       (i_load),
    .o_frame_start(o_frame_start),
    .shf          (shf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [7:0]  font [16];
  logic [11:0] exp_q [$];

  // Latest values handed to the DUT; these become the shown value at each frame boundary.
  logic [15:0] lv;
  logic [3:0]  ldp, lbl;

  bit          a_rst, a_load;
  logic [15:0] a_val;
  logic [3:0]  a_dp, a_bl;

  bit          in_frame, last_stall, prev_vld;
  int          cyc_in_frame, stalls, accepts, since_rst, since_mark, exp_gap, stall_left;
  logic [11:0] last_dat;

  initial begin
    bit          nrst, nload, nrdy;
    logic [15:0] nval;
    logic [3:0]  ndp, nbl;
    logic [3:0]  nib;
    logic [7:0]  seg;

    font = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    rst = 1'b1; i_load = 1'b0; i_value = '0; i_dp = '0; i_blank = '0; shf.i_rdy = 1'b1;
    a_rst = 1'b1; a_load = 1'b0; a_val = '0; a_dp = '0; a_bl = '0;
    lv = '0; ldp = '0; lbl = '0;
    in_frame = 0; last_stall = 0; prev_vld = 0;
    cyc_in_frame = 0; stalls = 0; accepts = 0; since_rst = 0; since_mark = 0;
    exp_gap = 1; stall_left = 0; last_dat = '0;

    for (int c = 0; c < 9000; c++) begin
      @(negedge clk);
      if (a_rst) begin
        lv = '0; ldp = '0; lbl = '0;
      end else if (a_load) begin
        lv = a_val; ldp = a_dp; lbl = a_bl;
      end

      if (a_rst) begin
        chk("rst_vld", 32'(shf.o_vld), 32'd0);
        chk("rst_data", 32'(shf.o_data), 32'hFFF);
        chk("rst_fstart", 32'(o_frame_start), 32'd0);
        in_frame = 0; last_stall = 0; since_rst = 0; exp_q.delete();
      end else begin
        since_rst++;
        since_mark++;
        if (in_frame) cyc_in_frame++;
        if (last_stall) begin
          chk("hold_vld", 32'(shf.o_vld), 32'd1);
          chk("hold_data", 32'(shf.o_data), 32'(last_dat));
        end
        if (!in_frame && since_rst == 1) chk("fstart_after_rst", 32'(o_frame_start), 32'd1);
        if (o_frame_start) begin
          if (in_frame) begin
            chk("frame_period", 32'(cyc_in_frame), 32'(PERIOD + stalls));
            chk("frame_accepts", 32'(accepts), 32'd4);
          end
          exp_q.delete();
          for (int k = 0; k < 4; k++) begin
            nib = 4'((lv >> (4 * k)) & 16'hF);
            if (lbl[k]) seg = 8'hFF;
            else if (ldp[k]) seg = font[nib] - 8'h80;
            else seg = font[nib];
            exp_q.push_back({seg, 4'(15 - (1 << k))});
          end
          in_frame = 1; cyc_in_frame = 0; stalls = 0; accepts = 0;
          since_mark = 0; exp_gap = 1;
        end else if (in_frame && cyc_in_frame > PERIOD + stalls) begin
          chk("frame_overrun", 32'(cyc_in_frame), 32'(PERIOD + stalls));
          in_frame = 0;
        end
        if (in_frame && shf.o_vld && !prev_vld)
          chk("vld_gap", 32'(since_mark), 32'(exp_gap));
      end
      prev_vld = shf.o_vld;

      // Next cycle's stimulus
      nval = a_val; ndp = a_dp; nbl = a_bl;
      if (c < 3) begin
        nrst = 1; nload = 0; nrdy = 1;
      end else if (c < 80) begin
        nrst = 0; nload = 0; nrdy = 1;
      end else begin
        if (stall_left > 0) begin
          nrdy = 0; stall_left--;
        end else if ($urandom_range(0, 19) == 0) begin
          nrdy = 0; stall_left = $urandom_range(1, 12);
        end else begin
          nrdy = ($urandom_range(0, 3) != 0);
        end
        nrst = ($urandom_range(0, 1499) == 0) ||
               (shf.o_vld && !nrdy && $urandom_range(0, 99) == 0);
        nload = !nrst && ($urandom_range(0, 15) == 0);
        if (nload) begin
          nval = 16'($urandom);
          ndp  = 4'($urandom);
          nbl  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
        end
      end

      last_stall = 0;
      if (!a_rst && !nrst && in_frame && shf.o_vld) begin
        if (nrdy) begin
          if (exp_q.size() > 0) chk("frame_data", 32'(shf.o_data), 32'(exp_q.pop_front()));
          accepts++;
          since_mark = 0; exp_gap = DW + 2;
        end else begin
          stalls++;
          last_stall = 1;
          last_dat = shf.o_data;
        end
      end

      rst = nrst; i_load = nload; i_value = nval; i_dp = ndp; i_blank = nbl; shf.i_rdy = nrdy;
      a_rst = nrst; a_load = nload; a_val = nval; a_dp = ndp; a_bl = nbl;
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
